// File: rtl/ifetch_pkg.sv
// Core definitions shared by the fetch front end.
// Entry layout and reset defaults live here.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue of {pc, instr} entries.
// Head is a registered read of the next-cycle head slot.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [AW-1:0] wr_next;
  logic [CW-1:0] cnt_next;
  fetch_entry_t  head_next;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    rd_next  = pop  ? rd_ptr + AW'(1) : rd_ptr;
    wr_next  = push ? wr_ptr + AW'(1) : wr_ptr;
    cnt_next = count;
    unique case (1'b1)
      push && !pop: cnt_next = count + CW'(1);
      pop && !push: cnt_next = count - CW'(1);
      default:      cnt_next = count;
    endcase
    // Entry written this cycle becomes head when the queue drains to it.
    head_next = head;
    if (cnt_next != '0) begin
      if (push && (wr_ptr == rd_next))
        head_next = wdata;
      else
        head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= cnt_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, redirect handling
// and the fetch queue towards decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign imem_addr = pc;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && (!full || pop);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    wdata.pc    = pc;
    wdata.instr = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(wdata),
    .count(count),
    .full (full),
    .empty(empty),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid
                  && (redirect_pc[1:0] != 2'b00);
      unique case (1'b1)
        redirect_valid:
          pc <= {redirect_pc[31:2], 2'b00};
        push:
          pc <= pc + 32'(INSTR_BYTES);
        default:
          pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit.
// Memory returns 32'h1000_0000 + word index.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;

  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;
  logic        misalign2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = 32'h1000_0000
                       + {20'b0, imem_addr[13:2]};
  assign imem_rdata2 = 32'h1000_0000
                       + {20'b0, imem_addr2[13:2]};

  ifetch_unit #(
    .DEPTH(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .misalign      (misalign)
  );

  ifetch_unit #(
    .DEPTH(2),
    .RESET_PC(32'hFFFF_FFF8)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr2),
    .imem_rdata    (imem_rdata2),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .out_valid     (out_valid2),
    .out_ready     (1'b1),
    .out_pc        (out_pc2),
    .out_instr     (out_instr2),
    .misalign      (misalign2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=%h",
               imem_addr, 32'h0);
    end
    total++;
    if ({out_valid, misalign} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00",
               {out_valid, misalign});
    end
    total++;
    if ({out_pc, out_instr} !== 64'h0) begin
      bad++;
      $display("FAIL reset_head got=%h_%h exp=0",
               out_pc, out_instr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      epc = 32'(i * 4);
      total++;
      if (imem_addr !== epc + 32'h4) begin
        bad++;
        $display("FAIL stream_addr%0d got=%h exp=%h",
                 i, imem_addr, epc + 32'h4);
      end
      total++;
      if (!out_valid || out_pc !== epc
          || out_instr !== 32'h1000_0000 + 32'(i)) begin
        bad++;
        $display("FAIL stream_head%0d got=%b %h %h exp=1 %h %h",
                 i, out_valid, out_pc, out_instr,
                 epc, 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] epc;
    do_reset(1'b0);
    step();
    step();
    step();
    total++;
    if (imem_addr !== 32'h8 || out_pc !== 32'h0
        || !out_valid) begin
      bad++;
      $display("FAIL bp_hold got=%h %h %b exp=8 0 1",
               imem_addr, out_pc, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      epc = 32'(i * 4);
      total++;
      if (!out_valid || out_pc !== epc
          || out_instr !== 32'h1000_0000 + 32'(i)) begin
        bad++;
        $display("FAIL bp_head%0d got=%b %h %h exp=1 %h",
                 i, out_valid, out_pc, out_instr, epc);
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100
        || misalign !== 1'b0) begin
      bad++;
      $display("FAIL redir_flush got=%b %h %b exp=0 100 0",
               out_valid, imem_addr, misalign);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (!out_valid || out_pc !== 32'h100
        || out_instr !== 32'h1000_0040) begin
      bad++;
      $display("FAIL redir_head got=%b %h %h exp=1 100 10000040",
               out_valid, out_pc, out_instr);
    end
    step();
    total++;
    if (!out_valid || out_pc !== 32'h104
        || out_instr !== 32'h1000_0041) begin
      bad++;
      $display("FAIL redir_next got=%b %h %h exp=1 104 10000041",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    total++;
    if (misalign !== 1'b1 || imem_addr !== 32'h100
        || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse got=%b %h %b exp=1 100 0",
               misalign, imem_addr, out_valid);
    end
    step();
    total++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL mis_clear got=%b exp=0", misalign);
    end
    total++;
    if (!out_valid || out_pc !== 32'h100
        || out_instr !== 32'h1000_0040) begin
      bad++;
      $display("FAIL mis_head got=%b %h %h exp=1 100 10000040",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] epc [3];
    logic [31:0] ein [3];
    epc[0] = 32'hFFFF_FFF8; ein[0] = 32'h1000_0FFE;
    epc[1] = 32'hFFFF_FFFC; ein[1] = 32'h1000_0FFF;
    epc[2] = 32'h0000_0000; ein[2] = 32'h1000_0000;
    do_reset(1'b1);
    total++;
    if (imem_addr2 !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL wrap_reset got=%h exp=fffffff8",
               imem_addr2);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (!out_valid2 || out_pc2 !== epc[i]
          || out_instr2 !== ein[i]) begin
        bad++;
        $display("FAIL wrap_head%0d got=%b %h %h exp=1 %h %h",
                 i, out_valid2, out_pc2, out_instr2,
                 epc[i], ein[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    do_reset(1'b0);
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstp_pre got=%b exp=1", out_valid);
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h201;
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || misalign !== 1'b0
        || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rstp_post got=%b %b %h exp=0 0 0",
               out_valid, misalign, imem_addr);
    end
    total++;
    if ({out_pc, out_instr} !== 64'h0) begin
      bad++;
      $display("FAIL rstp_head got=%h %h exp=0 0",
               out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
